// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Parallel-load, MSB-first serial transmitter with programmable
//               word repeat and a fixed idle gap between words.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int REP_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [REP_W-1:0] load_rep,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int c_BIT_W = $clog2(WIDTH);
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state,      w_state;
    logic [WIDTH-1:0]   r_hold,       w_hold;
    logic [WIDTH-1:0]   r_shift,      w_shift;
    logic [REP_W-1:0]   r_rep_left,   w_rep_left;
    logic [c_BIT_W-1:0] r_bit_cnt,    w_bit_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt,    w_gap_cnt;
    logic               r_sout,       w_sout;
    logic               r_sout_valid, w_sout_valid;
    logic               r_last,       w_last;
    logic               r_busy,       w_busy;
    logic               r_ready,      w_ready;
    logic [CNT_W-1:0]   r_words,      w_words;
    logic               w_reload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_shift      <= '0;
            r_rep_left   <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
            r_words      <= '0;
        end else begin
            r_state      <= w_state;
            r_hold       <= w_hold;
            r_shift      <= w_shift;
            r_rep_left   <= w_rep_left;
            r_bit_cnt    <= w_bit_cnt;
            r_gap_cnt    <= w_gap_cnt;
            r_sout       <= w_sout;
            r_sout_valid <= w_sout_valid;
            r_last       <= w_last;
            r_busy       <= w_busy;
            r_ready      <= w_ready;
            r_words      <= w_words;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_hold       = r_hold;
        w_shift      = r_shift;
        w_rep_left   = r_rep_left;
        w_bit_cnt    = r_bit_cnt;
        w_gap_cnt    = r_gap_cnt;
        w_sout       = 1'b0;
        w_sout_valid = 1'b0;
        w_last       = 1'b0;
        w_busy       = r_busy;
        w_ready      = r_ready;
        w_words      = r_words;
        w_reload     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_valid && r_ready) begin
                    w_hold       = load_data;
                    w_shift      = load_data << 1;
                    w_rep_left   = load_rep;
                    w_bit_cnt    = c_BIT_LAST;
                    w_sout       = load_data[WIDTH-1];
                    w_sout_valid = 1'b1;
                    w_ready      = 1'b0;
                    w_busy       = 1'b1;
                    w_state      = S_SHIFT;
                end else begin
                    w_ready = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_sout       = r_shift[WIDTH-1];
                    w_shift      = r_shift << 1;
                    w_sout_valid = 1'b1;
                    w_bit_cnt    = r_bit_cnt - c_BIT_W'(1);
                    w_last       = (r_bit_cnt == c_BIT_W'(1)) && (r_rep_left == '0);
                end else begin
                    // Word complete: the repeat decision is deferred to the end of the gap.
                    w_words   = r_words + CNT_W'(1);
                    w_gap_cnt = c_GAP_LAST;
                    if (GAP > 0) begin
                        w_state = S_GAP;
                    end else if (r_rep_left != '0) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_ready = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_cnt = r_gap_cnt - c_GAP_W'(1);
                end else if (r_rep_left != '0) begin
                    w_reload = 1'b1;
                    w_state  = S_SHIFT;
                end else begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_ready = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Next copy starts with its MSB; WIDTH >= 2 so it can never be the last bit.
        if (w_reload) begin
            w_rep_left   = r_rep_left - REP_W'(1);
            w_shift      = r_hold << 1;
            w_bit_cnt    = c_BIT_LAST;
            w_sout       = r_hold[WIDTH-1];
            w_sout_valid = 1'b1;
        end
    end

    assign load_ready = r_ready;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign last       = r_last;
    assign busy       = r_busy;
    assign words_sent = r_words;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_tx
// Description : Randomised, model-checked bench for two transmitter instances
//               (GAP=2/CNT_W=4 and GAP=0/CNT_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] lv, rdy, so, sv, la, bz;
    logic [7:0] ld [2];
    logic [3:0] lr [2];
    logic [3:0] ws0;
    logic [15:0] ws1;

    int chk  = 0;
    int pass = 0;

    bit         mact [2];
    bit         mrdy [2];
    int         pos  [2];
    int         mbase[2];
    int         mrep [2];
    int         acc  [2];
    logic [7:0] mdata[2];

    logic [255:0] cap  [2];
    int           capn [2];
    int           lastn[2];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .REP_W(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]),
        .load_data(ld[0]), .load_rep(lr[0]), .sout(so[0]), .sout_valid(sv[0]),
        .last(la[0]), .busy(bz[0]), .words_sent(ws0)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .REP_W(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]),
        .load_data(ld[1]), .load_rep(lr[1]), .sout(so[1]), .sout_valid(sv[1]),
        .last(la[1]), .busy(bz[1]), .words_sent(ws1)
    );

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int mask_of(input int i);
        return (i == 0) ? 'hF : 'hFFFF;
    endfunction

    task automatic check(input string nm, input int i, input int act, input int exp);
        chk++;
        if (act == exp) pass++;
        else $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    endtask

    // Transaction-level model: an accepted job is a timeline of (rep+1) periods of W+GAP cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mact[i] = 0; mrdy[i] = 0; pos[i] = 0; mbase[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mact[i]) begin
                    pos[i]++;
                    if (pos[i] == (mrep[i] + 1) * (W + gap_of(i))) begin
                        mact[i]  = 0;
                        mbase[i] = (mbase[i] + mrep[i] + 1) & mask_of(i);
                        mrdy[i]  = 1;
                    end
                end else if (mrdy[i] && lv[i]) begin
                    mact[i]  = 1;
                    mrdy[i]  = 0;
                    pos[i]   = 0;
                    mdata[i] = ld[i];
                    mrep[i]  = int'(lr[i]);
                    acc[i]++;
                end else begin
                    mrdy[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin : cmp
            int per, p, c, off, compl, e_w, act_w;
            logic e_v, e_s, e_l, e_b, e_r;
            per = W + gap_of(i);
            if (!mact[i]) begin
                e_v = 0; e_s = 0; e_l = 0; e_b = 0; e_r = mrdy[i]; e_w = mbase[i];
            end else begin
                p = pos[i];
                c = p / per;
                off = p % per;
                compl = 0;
                for (int j = 0; j <= mrep[i]; j++) if (j * per + W <= p) compl++;
                e_v = (off < W);
                e_s = e_v ? mdata[i][W-1-off] : 1'b0;
                e_l = e_v && (c == mrep[i]) && (off == W - 1);
                e_b = 1; e_r = 0;
                e_w = (mbase[i] + compl) & mask_of(i);
            end
            act_w = (i == 0) ? int'(ws0) : int'(ws1);
            check("sout",       i, int'(so[i]),  int'(e_s));
            check("sout_valid", i, int'(sv[i]),  int'(e_v));
            check("last",       i, int'(la[i]),  int'(e_l));
            check("busy",       i, int'(bz[i]),  int'(e_b));
            check("load_ready", i, int'(rdy[i]), int'(e_r));
            check("words_sent", i, act_w,        e_w);
            if (sv[i]) begin
                cap[i] = {cap[i][254:0], so[i]};
                capn[i]++;
            end
            if (la[i]) lastn[i]++;
        end
    end

    function automatic int tail(input int i, input int k);
        int v = 0;
        for (int b = k - 1; b >= 0; b--) v = (v << 1) | int'(cap[i][b]);
        return v;
    endfunction

    task automatic send(input int i, input logic [7:0] d, input int r, input int hold);
        int a0;
        bit got;
        a0 = acc[i];
        got = 0;
        lv[i] = 1'b1; ld[i] = d; lr[i] = 4'(r);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk); #1;
            if (acc[i] != a0) begin got = 1; break; end
        end
        check("accepted", i, int'(got), 1);
        ld[i] = 8'($urandom);
        lr[i] = 4'($urandom);
        repeat (hold) @(negedge clk);
        lv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        bit ok;
        ok = 0;
        for (int t = 0; t < 800; t++) begin
            if (!mact[i] && mrdy[i]) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        check("idle_reached", i, int'(ok), 1);
    endtask

    task automatic measure_ready(input int i, output int n);
        n = 1;
        for (int t = 0; t < 100; t++) begin
            if (rdy[i]) break;
            @(negedge clk); #1;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, n0, l0, ri, rr;
        lv = '0; ld[0] = '0; ld[1] = '0; lr[0] = '0; lr[1] = '0;
        acc[0] = 0; acc[1] = 0; capn[0] = 0; capn[1] = 0; lastn[0] = 0; lastn[1] = 0;
        cap[0] = '0; cap[1] = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk); #1;
        check("rdy_in_reset", 0, int'(rdy[0]), 0);
        check("valid_in_reset", 1, int'(sv[1]), 0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rdy_after_release", 0, int'(rdy[0]), 1);
        check("rdy_after_release", 1, int'(rdy[1]), 1);

        n0 = capn[0]; l0 = lastn[0];
        send(0, 8'hB4, 0, 0);
        measure_ready(0, n);
        check("b4_ready_cycle", 0, n, 11);
        wait_idle(0);
        check("b4_bits", 0, tail(0, 8), 'hB4);
        check("b4_count", 0, capn[0] - n0, 8);
        check("b4_last", 0, lastn[0] - l0, 1);
        check("b4_words", 0, int'(ws0), 1);

        n0 = capn[0]; l0 = lastn[0];
        send(0, 8'h81, 2, 0);
        wait_idle(0);
        check("rep_bits", 0, tail(0, 24), 'h818181);
        check("rep_count", 0, capn[0] - n0, 24);
        check("rep_last", 0, lastn[0] - l0, 1);
        check("rep_words", 0, int'(ws0), 4);

        n0 = capn[1]; l0 = lastn[1];
        send(1, 8'hFF, 1, 0);
        measure_ready(1, n);
        check("gap0_ready_cycle", 1, n, 17);
        check("gap0_bits", 1, tail(1, 16), 'hFFFF);
        check("gap0_count", 1, capn[1] - n0, 16);
        check("gap0_last", 1, lastn[1] - l0, 1);
        send(1, 8'h5A, 0, 0);
        check("gap0_restart_valid", 1, int'(sv[1]), 1);
        wait_idle(1);
        check("gap0_words", 1, int'(ws1), 3);

        n0 = capn[0];
        send(0, 8'hA5, 0, 2);
        @(negedge clk); #1;
        check("abort_prefix", 0, tail(0, 4), 'hA);
        check("abort_prefix_count", 0, capn[0] - n0, 4);
        rst = 1'b0;
        #1;
        check("abort_valid", 0, int'(sv[0]), 0);
        check("abort_words", 0, int'(ws0), 0);
        check("abort_busy", 0, int'(bz[0]), 0);
        check("abort_words", 1, int'(ws1), 0);
        repeat (2) @(negedge clk); #1;
        rst = 1'b1;

        n0 = capn[0];
        send(0, 8'h3C, 0, 0);
        wait_idle(0);
        check("clean_bits", 0, tail(0, 8), 'h3C);
        check("clean_count", 0, capn[0] - n0, 8);
        check("clean_words", 0, int'(ws0), 1);

        for (int k = 2; k <= 16; k++) begin
            send(0, 8'($urandom), 0, 0);
            wait_idle(0);
            if (k == 15) check("wrap_15", 0, int'(ws0), 15);
        end
        check("wrap_0", 0, int'(ws0), 0);

        n0 = capn[0]; l0 = lastn[0];
        send(0, 8'hC3, 15, 0);
        wait_idle(0);
        check("maxrep_count", 0, capn[0] - n0, 128);
        check("maxrep_last", 0, lastn[0] - l0, 1);
        check("maxrep_words", 0, int'(ws0), 0);

        for (int t = 0; t < 40; t++) begin
            ri = int'($urandom_range(1, 0));
            rr = ($urandom_range(4, 0) == 0) ? int'($urandom_range(15, 0)) : int'($urandom_range(2, 0));
            repeat ($urandom_range(3, 0)) @(negedge clk);
            send(ri, 8'($urandom), rr, int'($urandom_range(3, 0)));
            if ($urandom_range(1, 0) == 1) wait_idle(ri);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter: the sending end of the one-bit serial stream that the team's sequence-detector FSMs consume.
- Accepts a parallel word over a valid/ready load port and shifts it out MSB-first, one bit per clock.
- Optionally repeats the word N extra times, with a programmable idle gap between words.
- Drives detector inputs in the datapath and in bring-up benches.

Parameters:
WIDTH, 8, bits per word (>=2)
GAP, 2, idle cycles after every word (0 allowed)
REP_W, 4, width of repeat-count field
CNT_W, 16, width of words_sent counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
load_valid  in  1  word offered
load_ready  out  1  block can accept a word (IDLE only)
load_data  in  WIDTH  word to send, MSB first
load_rep  in  REP_W  extra repeats (0 = send once)
sout  out  1  serial data bit
sout_valid  out  1  sout carries a data bit this cycle
last  out  1  final bit of final repeat
busy  out  1  state != IDLE
words_sent  out  CNT_W  count of completed words, wraps

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; sout, sout_valid, last, busy, load_ready and words_sent all 0; shift/hold/counters cleared. load_ready rises on the first clk edge after rst goes high.
- All outputs are registered.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid & load_ready (accept edge E0): latch load_data into hold and shift registers; rep_left<=load_rep; bit_cnt<=WIDTH-1; sout<=load_data[WIDTH-1]; sout_valid<=1; load_ready<=0; busy<=1; state<=SHIFT.
- SHIFT:
  - Bit k (k=0..WIDTH-1, MSB first) is presented in the cycle after edge E_k. sout_valid=1 for exactly WIDTH consecutive cycles.
  - last=1 only with bit WIDTH-1 when rep_left==0.
  - At edge E_WIDTH (word complete), words_sent increments, wrapping from 2^CNT_W-1 to 0.
  - If rep_left>0: rep_left decrements and the shift register reloads from hold. With GAP>0 go to GAP; with GAP=0 go straight to SHIFT, so the next word's MSB follows the previous LSB with no bubble.
  - If rep_left==0: with GAP>0 go to GAP; with GAP=0 go to IDLE.
- GAP:
  - sout=0, sout_valid=0, last=0 for exactly GAP cycles.
  - Then go to SHIFT (repeat pending) or IDLE.
  - On entry to IDLE, load_ready=1 and busy=0 in the same cycle.
- Throughput, single word, no repeats: accept to next possible accept is WIDTH+GAP+1 edges.
- load_valid outside IDLE is ignored. load_data and load_rep are sampled only at the accept edge; later changes have no effect.
- sout is 0 whenever sout_valid=0.
- Reset mid-word: immediate abort. Outputs go to reset values, words_sent=0, and the partial word is neither counted nor resumed.
- load_rep=2^REP_W-1 sends 2^REP_W copies; no overflow in rep_left.

Test Plan:
1. Reset: rst low for 3 cycles, then high. Required: all outputs 0 during reset; load_ready=1 after the first edge; no sout_valid.
2. Single word, WIDTH=8, GAP=2: load 8'hB4, rep 0. Required: sout=1,0,1,1,0,1,0,0 with sout_valid=1 for 8 cycles; last only on the 8th; 2 cycles with sout_valid=0; load_ready=1 on the 11th cycle after accept; words_sent=1.
3. Repeat: load 8'h81, rep 2. Required: three copies of 1,0,0,0,0,0,0,1, each pair separated by exactly 2 invalid cycles; 24 valid bits total; last asserted once; words_sent +3.
4. GAP=0 instance: load 8'hFF, rep 1. Required: 16 contiguous valid 1s; last on the 16th; load_ready=1 in the following cycle; a second word accepted immediately continues with a 1-cycle bubble only.
5. Protocol and abort: hold load_valid=1 with new data during SHIFT; it must be ignored. Pull rst low during bit 3 of 8'hA5. Required: sout_valid=0 asynchronously and words_sent=0; a new 8'h3C afterwards is sent cleanly as 0,0,1,1,1,1,0,0.
6. Counter wrap, CNT_W=4: send 16 words. Required: words_sent steps 1..15, then 0 on the 16th completion.
